// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings, fill owner and block geometry.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_FILL  = 2'b10
  } state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int BLK_OFF_BITS = 4;
  localparam int WORD_IDX_W   = 3;

endpackage

// File: rtl/mem_arbiter_blk_word_counter.sv
// 4-bit block word counter (0..8) with synchronous clear and increment.
module blk_word_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       done_at_7
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 4'd0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done_at_7 = (cnt == 4'd7);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and D-side write-through stores,
// sequencing each 8-word block fill and steering returned words to the owning cache.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [2:0]        fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_done,
  output logic              busy
);

  if (MEM_LAT < 1 || BLK_WORDS != 8 || ADDR_W <= BLK_OFF_BITS) begin : g_bad_param
    $error("mem_arbiter: unsupported parameterisation");
  end

  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BLK_OFF_BITS) - 1);

  state_t            state_q;
  state_t            state_d;
  owner_t            owner_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        issue_cnt;
  logic [3:0]        recv_cnt;
  logic              issue_last;
  logic              recv_last;
  logic              issue_en;
  logic              recv_vld;
  logic              cnt_clr;
  logic              d_side_req;
  logic              spurious_vld;

  assign d_side_req   = d_wr || d_req;
  assign cnt_clr      = (state_q != ST_FILL);
  assign issue_en     = (state_q == ST_FILL) && (issue_cnt < 4'(BLK_WORDS));
  // Stray returns (outside a fill or after the 8th word) must never reach a cache.
  assign recv_vld     = (state_q == ST_FILL) && mem_valid && !recv_cnt[3];
  assign spurious_vld = mem_valid && !recv_vld;

  blk_word_counter u_issue_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (issue_en),
    .cnt       (issue_cnt),
    .done_at_7 (issue_last)
  );

  blk_word_counter u_recv_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (recv_vld),
    .cnt       (recv_cnt),
    .done_at_7 (recv_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_I;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        owner_q <= d_side_req ? OWNER_D : OWNER_I;
      end
    end
  end

  // Block base is captured with the offset bits zeroed; fills always start at word 0.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE) begin
      base_q <= (d_side_req ? d_addr : i_addr) & ~BLK_MASK;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (d_wr) begin
          state_d = ST_WRITE;
        end else if (d_req || i_req) begin
          state_d = ST_FILL;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FILL: begin
        if (recv_vld && recv_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    fill_idx  = 3'd0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    d_wr_done = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_wr_done = 1'b1;
      end
      ST_FILL: begin
        if (issue_en) begin
          mem_en   = 1'b1;
          mem_addr = base_q | ADDR_W'({issue_cnt[WORD_IDX_W-1:0], 1'b0});
        end
        if (recv_vld) begin
          fill_idx = recv_cnt[WORD_IDX_W-1:0];
          if (owner_q == OWNER_D) begin
            d_fill_we = 1'b1;
            d_done    = recv_last;
          end else begin
            i_fill_we = 1'b1;
            i_done    = recv_last;
          end
        end
      end
      default: ;
    endcase
  end

  assign fill_data = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!spurious_vld)
        else $warning("mem_arbiter: mem_valid with no outstanding fill read, ignored");
      assert (!(issue_last && issue_en && recv_vld && recv_last))
        else $error("mem_arbiter: last word returned before last read issued");
    end
  end

endmodule
